// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display capture block: segment
// patterns (active-low, CA..CG from MSB), blank anode value and FSM states.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_e;

  localparam logic [7:0] BLANK_ANODE = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  // True when exactly one anode line is driven low.
  function automatic logic one_hot_low(input logic [7:0] an);
    logic [7:0] x;
    x = ~an;
    return (x != 8'h00) && ((x & (x - 8'd1)) == 8'h00);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to hex decoder; hit is low for any pattern
// outside the 16-entry table (including all segments off).
module seg7_decode
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Captures a multiplexed 8-digit seven-segment scan into a 32-bit value.
// Define DISPLAY_CAPTURE_DP_EN to also capture the decimal points on dp.
module display_capture
  import display_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  cathode,
  input  logic [7:0]  anode,
  output logic [31:0] data,
  output logic        valid,
  output logic        frame_done,
  output logic        digit_err,
  output logic [7:0]  dp
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [7:0]  cathode_q, cathode_d, cathode_prev_q, anode_q, anode_prev_q;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, seen_q, seen_d, seen_base;
  logic [31:0] shadow_q, shadow_d, data_q, data_d;
  logic        valid_q, valid_d, frame_done_q, frame_done_d;
  logic        digit_err_q, digit_err_d;
  logic        changed, sample, legal, write, hit;
  logic [3:0]  nibble;
  logic [2:0]  digit_idx;

  seg7_decode u_decode (
    .seg    (cathode_q[7:1]),
    .nibble (nibble),
    .hit    (hit)
  );

`ifdef DISPLAY_CAPTURE_DP_EN
  logic [7:0] dp_shadow_q, dp_shadow_d, dp_q, dp_d;
  assign cathode_d = cathode;
  assign dp        = dp_q;
`else
  // The decimal point is forced off so it never disturbs change detection.
  logic unused_cathode_dp;
  assign unused_cathode_dp = cathode[0];
  assign cathode_d         = {cathode[7:1], 1'b1};
  assign dp                = 8'h00;
`endif

  always_comb begin
    digit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!anode_q[i]) digit_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    changed = (anode_q != anode_prev_q) || (cathode_q != cathode_prev_q);
    case (state_q)
      IDLE: begin
        if (anode_q != BLANK_ANODE) begin
          state_d = SETTLE;
          cnt_d   = 8'd0;
        end
      end
      SETTLE: begin
        if (changed) begin
          state_d = (anode_q == BLANK_ANODE) ? IDLE : SETTLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          sample  = 1'b1;
          state_d = HELD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (changed) begin
          state_d = (anode_q == BLANK_ANODE) ? IDLE : SETTLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // A full mask is consumed by the frame copy in the same cycle it is seen.
  always_comb begin
    legal        = one_hot_low(anode_q) && hit;
    write        = sample && legal;
    digit_err_d  = sample && !legal;
    frame_done_d = (seen_q == 8'hFF);
    seen_base    = frame_done_d ? 8'h00 : seen_q;
    seen_d       = write ? (seen_base | (8'h01 << digit_idx)) : seen_base;
    shadow_d     = shadow_q;
    if (write) shadow_d[{digit_idx, 2'b00} +: 4] = nibble;
    data_d       = frame_done_d ? shadow_q : data_q;
    valid_d      = valid_q | frame_done_d;
  end

`ifdef DISPLAY_CAPTURE_DP_EN
  always_comb begin
    dp_shadow_d = dp_shadow_q;
    if (write) dp_shadow_d[digit_idx] = ~cathode_q[0];
    dp_d = frame_done_d ? dp_shadow_q : dp_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dp_shadow_q <= 8'h00;
      dp_q        <= 8'h00;
    end else begin
      dp_shadow_q <= dp_shadow_d;
      dp_q        <= dp_d;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cathode_q      <= 8'hFF;
      cathode_prev_q <= 8'hFF;
      anode_q        <= BLANK_ANODE;
      anode_prev_q   <= BLANK_ANODE;
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      seen_q         <= 8'h00;
      shadow_q       <= 32'h0;
      data_q         <= 32'h0;
      valid_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      digit_err_q    <= 1'b0;
    end else begin
      cathode_q      <= cathode_d;
      cathode_prev_q <= cathode_q;
      anode_q        <= anode;
      anode_prev_q   <= anode_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      seen_q         <= seen_d;
      shadow_q       <= shadow_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      frame_done_q   <= frame_done_d;
      digit_err_q    <= digit_err_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;
  assign digit_err  = digit_err_q;

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench for display_capture: stimulus pushes expected frame and
// error events; a negedge monitor pops and compares them as the DUT reports.
module tb_display_capture;

`ifdef DISPLAY_CAPTURE_DP_EN
  localparam logic [7:0] DP_EXP_81 = 8'h81;
`else
  localparam logic [7:0] DP_EXP_81 = 8'h00;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cathode = 8'hFF;
  logic [7:0]  anode = 8'hFF;
  logic [31:0] data;
  logic        valid, frame_done, digit_err;
  logic [7:0]  dp;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    logic [7:0]  dp;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  display_capture #(.SETTLE_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cathode    (cathode),
    .anode      (anode),
    .data       (data),
    .valid      (valid),
    .frame_done (frame_done),
    .digit_err  (digit_err),
    .dp         (dp)
  );

  // Independent hand-written active-low segment table (a..g from MSB).
  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] an, input logic [7:0] cath, input int cycles);
    anode   = an;
    cathode = cath;
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic showDigit(input int idx, input logic [3:0] n, input bit dp_on);
    applyStimulus(~(8'h01 << idx), {segOf(n), ~dp_on}, 16);
    applyStimulus(8'hFF, 8'hFF, 2);
  endtask

  task automatic pushFrame(input logic [31:0] d, input logic [7:0] p);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    e.dp     = p;
    sb.push_back(e);
  endtask

  task automatic pushErr();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = 32'h0;
    e.dp     = 8'h00;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per reported event; outputs must hold otherwise.
  initial begin
    logic [31:0] last_data;
    logic [7:0]  last_dp;
    logic        last_valid;
    exp_t        e;
    last_data  = 32'h0;
    last_dp    = 8'h00;
    last_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        last_data  = 32'h0;
        last_dp    = 8'h00;
        last_valid = 1'b0;
      end else begin
        if (frame_done || digit_err) begin
          checkOutput("event_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.is_err) begin
              checkOutput("digit_err_pulse", 32'(digit_err), 32'd1);
              checkOutput("no_frame_on_err", 32'(frame_done), 32'd0);
            end else begin
              checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
              checkOutput("frame_data", data, e.data);
              checkOutput("frame_dp", 32'(dp), 32'(e.dp));
              checkOutput("frame_valid", 32'(valid), 32'd1);
              checkOutput("no_err_on_frame", 32'(digit_err), 32'd0);
            end
          end
        end
        if (!frame_done) begin
          checkOutput("data_hold", data, last_data);
          checkOutput("dp_hold", 32'(dp), 32'(last_dp));
          checkOutput("valid_hold", 32'(valid), 32'(last_valid));
        end
        last_data  = data;
        last_dp    = dp;
        last_valid = valid;
      end
    end
  end

  initial begin
    logic [31:0] v;
    $display("[TB] starting display_capture bench");

    repeat (2) @(negedge clock);
    checkOutput("reset_data", data, 32'h0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_dp", 32'(dp), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_digit_err", 32'(digit_err), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(8'hFF, 8'hFF, 4);

    // Plain scan with decimal points on digits 0 and 7.
    v = 32'h1234_5678;
    for (int i = 0; i < 7; i++) showDigit(i, v[4*i +: 4], (i == 0));
    @(negedge clock);
    checkOutput("valid_before_first_frame", 32'(valid), 32'd0);
    pushFrame(32'h1234_5678, DP_EXP_81);
    showDigit(7, v[31:28], 1'b1);

    // Digit 3 sees glitches that must never be sampled; only a held SEG_1 lands.
    v = 32'hFEDC_1BA9;
    for (int i = 0; i < 3; i++) showDigit(i, v[4*i +: 4], 1'b0);
    applyStimulus(8'hF7, {segOf(4'h7), 1'b1}, 3);
    applyStimulus(8'hF7, {segOf(4'h1), 1'b1}, 2);
    applyStimulus(8'hFF, 8'hFF, 2);
    applyStimulus(8'hF7, {segOf(4'h7), 1'b1}, 3);
    applyStimulus(8'hF7, {segOf(4'h1), 1'b1}, 14);
    applyStimulus(8'hF7, {segOf(4'h7), 1'b1}, 3);
    applyStimulus(8'hFF, 8'hFF, 2);
    for (int i = 4; i < 7; i++) showDigit(i, v[4*i +: 4], 1'b0);
    pushFrame(32'hFEDC_1BA9, 8'h00);
    showDigit(7, v[31:28], 1'b0);

    // Illegal samples: each held long, so any resample would be an extra event.
    pushErr();
    applyStimulus(8'hFC, {segOf(4'h5), 1'b1}, 20);
    applyStimulus(8'hFF, 8'hFF, 2);
    pushErr();
    applyStimulus(8'hFE, 8'hFF, 20);
    applyStimulus(8'hFF, 8'hFF, 2);
    v = 32'h3141_5926;
    for (int i = 1; i < 8; i++) showDigit(i, v[4*i +: 4], 1'b0);
    pushFrame(32'h3141_5926, 8'h00);
    showDigit(0, v[3:0], 1'b0);

    // Partial frame discarded by reset, then a clean all-F frame.
    v = 32'h90AB_CDEF;
    for (int i = 0; i < 5; i++) showDigit(i, v[4*i +: 4], 1'b1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_data", data, 32'h0);
    checkOutput("midreset_valid", 32'(valid), 32'd0);
    checkOutput("midreset_dp", 32'(dp), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(8'hFF, 8'hFF, 3);
    for (int i = 0; i < 7; i++) showDigit(i, 4'hF, 1'b0);
    @(negedge clock);
    checkOutput("valid_after_reset", 32'(valid), 32'd0);
    checkOutput("data_after_reset", data, 32'h0);
    pushFrame(32'hFFFF_FFFF, 8'h00);
    showDigit(7, 4'hF, 1'b0);

    applyStimulus(8'hFF, 8'hFF, 10);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
